// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the intersection scheduler slice.
//   state_t : 3-bit phase encodings, also exported on the debug state port
//   LT_*    : one-hot {R,Y,G} lamp codes driven onto ns_light / ew_light
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G       = 3'd0,
        NS_Y       = 3'd1,
        AR_TO_EW   = 3'd2,
        EW_G       = 3'd3,
        EW_Y       = 3'd4,
        AR_TO_NS   = 3'd5,
        WALK_TO_EW = 3'd6,
        WALK_TO_NS = 3'd7
    } state_t;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    // True for both pedestrian phases, which share the same lamp pattern.
    function automatic logic is_walk(input state_t s);
        return (s == WALK_TO_EW) || (s == WALK_TO_NS);
    endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer
// Saturating phase timer shared by every phase of the scheduler.
// Ports:
//   clk, res      : rising-edge clock, synchronous active-high reset
//   en            : count enable; the counter holds when low
//   clr           : clear to zero (phase change), wins over counting
//   count         : current phase age in enabled cycles
//   at_min_green  : count has reached the minimum green length
//   at_max_green  : count is saturated at the maximum green length
module traffic_phase_timer #(
    parameter int CNT_W       = 5,
    parameter int T_MIN_GREEN = 8,
    parameter int T_MAX_GREEN = 20
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             at_min_green,
    output logic             at_max_green
);

    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(T_MAX_GREEN - 1);

    // Saturating at the max-green value keeps an idle green from wrapping
    // and lets the max-out compare stay true while the road holds.
    always_ff @(posedge clk) begin
        if (res) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign at_min_green = (count >= CNT_MIN);
    assign at_max_green = (count == CNT_MAX);

endmodule

// File: rtl/traffic_intersection_scheduler.sv
// traffic_intersection_scheduler
// Right-of-way sequencer for a two-road intersection with a pedestrian
// crossing. Greens gap out once the minimum green is served and the own
// road is empty, or max out while the opposing side keeps demanding.
// Ports:
//   clk, res     : rising-edge clock, synchronous active-high reset
//   en           : advance enable; low freezes state and timer
//   car_ns       : vehicle presence on North-South
//   car_ew       : vehicle presence on East-West
//   ped_req      : pedestrian button, sampled every cycle
//   ns_light     : NS lamp, one-hot {R,Y,G}
//   ew_light     : EW lamp, one-hot {R,Y,G}
//   walk         : pedestrian walk lamp
//   ped_pending  : latched pedestrian request not yet served
//   state        : current phase encoding, for debug
module traffic_intersection_scheduler
    import traffic_pkg::*;
#(
    parameter int T_MIN_GREEN = 8,
    parameter int T_MAX_GREEN = 20,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 1,
    parameter int T_WALK      = 6,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       res,
    input  logic       en,
    input  logic       car_ns,
    input  logic       car_ew,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] YEL_END  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_END   = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] WALK_END = CNT_W'(T_WALK - 1);

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] phase_cnt;
    logic             at_min_green;
    logic             at_max_green;
    logic             state_change;
    logic             entering_walk;

    // A phase change only happens on an enabled cycle, so the timer clear
    // and the state update always land on the same edge.
    assign state_change  = (nxt_state != cur_state);
    assign entering_walk = is_walk(nxt_state) && !is_walk(cur_state);

    traffic_phase_timer #(
        .CNT_W       (CNT_W),
        .T_MIN_GREEN (T_MIN_GREEN),
        .T_MAX_GREEN (T_MAX_GREEN)
    ) u_timer (
        .clk          (clk),
        .res          (res),
        .en           (en),
        .clr          (state_change),
        .count        (phase_cnt),
        .at_min_green (at_min_green),
        .at_max_green (at_max_green)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (res) begin
            cur_state <= NS_G;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic. A green leaves only with opposing demand, after the
    // minimum green, and then either when its own road empties (gap-out)
    // or when the saturated timer signals max-out.
    always_comb begin
        nxt_state = cur_state;
        if (en) begin
            case (cur_state)
                NS_G: begin
                    if ((car_ew || ped_pending) && at_min_green &&
                        (!car_ns || at_max_green)) begin
                        nxt_state = NS_Y;
                    end
                end
                NS_Y: begin
                    if (phase_cnt == YEL_END) nxt_state = AR_TO_EW;
                end
                AR_TO_EW: begin
                    if (phase_cnt == AR_END) begin
                        nxt_state = ped_pending ? WALK_TO_EW : EW_G;
                    end
                end
                WALK_TO_EW: begin
                    if (phase_cnt == WALK_END) nxt_state = EW_G;
                end
                EW_G: begin
                    if ((car_ns || ped_pending) && at_min_green &&
                        (!car_ew || at_max_green)) begin
                        nxt_state = EW_Y;
                    end
                end
                EW_Y: begin
                    if (phase_cnt == YEL_END) nxt_state = AR_TO_NS;
                end
                AR_TO_NS: begin
                    if (phase_cnt == AR_END) begin
                        nxt_state = ped_pending ? WALK_TO_NS : NS_G;
                    end
                end
                WALK_TO_NS: begin
                    if (phase_cnt == WALK_END) nxt_state = NS_G;
                end
                default: nxt_state = NS_G;
            endcase
        end
    end

    // Pedestrian request latch. It captures presses even while frozen; the
    // edge that starts a walk clears it and swallows a same-cycle press, and
    // presses during a walk are already being served so they are dropped.
    always_ff @(posedge clk) begin
        if (res) begin
            ped_pending <= 1'b0;
        end else if (entering_walk) begin
            ped_pending <= 1'b0;
        end else if (ped_req && !is_walk(cur_state)) begin
            ped_pending <= 1'b1;
        end
    end

    // Lamp decode from the registered state; red everywhere unless a road
    // owns the phase, so both roads can never be non-red together.
    always_comb begin
        ns_light = LT_RED;
        ew_light = LT_RED;
        walk     = 1'b0;
        case (cur_state)
            NS_G:       ns_light = LT_GRN;
            NS_Y:       ns_light = LT_YEL;
            EW_G:       ew_light = LT_GRN;
            EW_Y:       ew_light = LT_YEL;
            WALK_TO_EW: walk     = 1'b1;
            WALK_TO_NS: walk     = 1'b1;
            default:    walk     = 1'b0;
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_traffic_intersection_scheduler.sv
// tb_traffic_intersection_scheduler
// Directed scenarios for the intersection scheduler. Each driven cycle
// pushes the hand-derived expected phase into a scoreboard queue; an
// independent monitor pops and compares on the falling edge.
module tb_traffic_intersection_scheduler;
    import traffic_pkg::*;

    logic       clk;
    logic       res;
    logic       en;
    logic       car_ns;
    logic       car_ew;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       ped_pending;
    logic [2:0] state;

    typedef struct packed {
        logic [7:0] scen;
        logic [2:0] st;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       wk;
        logic       pp;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    logic [7:0] cur_scen;

    traffic_intersection_scheduler dut (
        .clk         (clk),
        .res         (res),
        .en          (en),
        .car_ns      (car_ns),
        .car_ew      (car_ew),
        .ped_req     (ped_req),
        .ns_light    (ns_light),
        .ew_light    (ew_light),
        .walk        (walk),
        .ped_pending (ped_pending),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected lamp pattern per phase, written out from the lamp table.
    function automatic exp_t makeExp(input state_t s, input logic pp);
        exp_t e;
        e.scen = cur_scen;
        e.st   = s;
        e.pp   = pp;
        e.wk   = 1'b0;
        e.ns   = 3'b100;
        e.ew   = 3'b100;
        case (s)
            NS_G:       e.ns = 3'b001;
            NS_Y:       e.ns = 3'b010;
            EW_G:       e.ew = 3'b001;
            EW_Y:       e.ew = 3'b010;
            WALK_TO_EW: e.wk = 1'b1;
            WALK_TO_NS: e.wk = 1'b1;
            default:    e.wk = 1'b0;
        endcase
        return e;
    endfunction

    // Compare one observed cycle against the popped expectation.
    task automatic checkOutput(input exp_t e);
        checks++;
        if (state !== e.st || ns_light !== e.ns || ew_light !== e.ew ||
            walk !== e.wk || ped_pending !== e.pp) begin
            errors++;
            $display("[TB] FAIL scen%0d obs: got st=%0d ns=%b ew=%b walk=%b pp=%b, want st=%0d ns=%b ew=%b walk=%b pp=%b",
                     e.scen, state, ns_light, ew_light, walk, ped_pending,
                     e.st, e.ns, e.ew, e.wk, e.pp);
        end
    endtask

    // Monitor: every pushed cycle is consumed on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    // Drive one cycle's inputs, record what the DUT should show during it,
    // then step past the next rising edge.
    task automatic applyStimulus(input logic cn, input logic ce, input logic pr,
                                 input logic e, input state_t s, input logic pp);
        car_ns  = cn;
        car_ew  = ce;
        ped_req = pr;
        en      = e;
        exp_q.push_back(makeExp(s, pp));
        @(posedge clk);
        #1;
    endtask

    task automatic runPhase(input state_t s, input int n, input logic cn,
                            input logic ce, input logic pr, input logic e,
                            input logic pp);
        for (int i = 0; i < n; i++) applyStimulus(cn, ce, pr, e, s, pp);
    endtask

    task automatic doReset();
        res     = 1'b1;
        en      = 1'b0;
        car_ns  = 1'b0;
        car_ew  = 1'b0;
        ped_req = 1'b0;
        @(posedge clk);
        #1;
        res = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cur_scen = 8'd0;
        res      = 1'b1;
        en       = 1'b0;
        car_ns   = 1'b0;
        car_ew   = 1'b0;
        ped_req  = 1'b0;

        // 1: EW demand only, NS gaps out after minimum green.
        cur_scen = 8'd1;
        doReset();
        runPhase(NS_G,     8, 0, 1, 0, 1, 0);
        runPhase(NS_Y,     3, 0, 1, 0, 1, 0);
        runPhase(AR_TO_EW, 1, 0, 1, 0, 1, 0);
        runPhase(EW_G,     5, 0, 1, 0, 1, 0);

        // 2: both roads busy, each green maxes out.
        cur_scen = 8'd2;
        doReset();
        runPhase(NS_G,     20, 1, 1, 0, 1, 0);
        runPhase(NS_Y,      3, 1, 1, 0, 1, 0);
        runPhase(AR_TO_EW,  1, 1, 1, 0, 1, 0);
        runPhase(EW_G,     20, 1, 1, 0, 1, 0);
        runPhase(EW_Y,      3, 1, 1, 0, 1, 0);
        runPhase(AR_TO_NS,  1, 1, 1, 0, 1, 0);
        runPhase(NS_G,      2, 1, 1, 0, 1, 0);

        // 3: pedestrian only; press absorbed on walk entry, ignored in walk.
        cur_scen = 8'd3;
        doReset();
        runPhase(NS_G, 2, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1, NS_G, 0);
        runPhase(NS_G, 5, 0, 0, 0, 1, 1);
        runPhase(NS_Y, 3, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 1, 1, AR_TO_EW, 1);
        runPhase(WALK_TO_EW, 2, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1, WALK_TO_EW, 0);
        runPhase(WALK_TO_EW, 3, 0, 0, 0, 1, 0);
        runPhase(EW_G, 6, 0, 0, 0, 1, 0);

        // 4: no demand at all, NS green holds indefinitely.
        cur_scen = 8'd4;
        doReset();
        runPhase(NS_G, 100, 0, 0, 0, 1, 0);

        // 5: freeze during yellow; a frozen press still latches.
        cur_scen = 8'd5;
        doReset();
        runPhase(NS_G, 8, 0, 1, 0, 1, 0);
        applyStimulus(0, 1, 0, 1, NS_Y, 0);
        applyStimulus(0, 1, 0, 0, NS_Y, 0);
        applyStimulus(0, 1, 1, 0, NS_Y, 0);
        runPhase(NS_Y, 3, 0, 1, 0, 0, 1);
        runPhase(NS_Y, 2, 0, 1, 0, 1, 1);
        runPhase(AR_TO_EW, 1, 0, 1, 0, 1, 1);
        runPhase(WALK_TO_EW, 6, 0, 1, 0, 1, 0);
        runPhase(EW_G, 3, 0, 1, 0, 1, 0);

        // 6: reset in EW yellow with a pending press, then a clean restart.
        cur_scen = 8'd6;
        doReset();
        runPhase(NS_G,     20, 1, 1, 0, 1, 0);
        runPhase(NS_Y,      3, 1, 1, 0, 1, 0);
        runPhase(AR_TO_EW,  1, 1, 1, 0, 1, 0);
        applyStimulus(1, 1, 1, 1, EW_G, 0);
        runPhase(EW_G,     19, 1, 1, 0, 1, 1);
        applyStimulus(1, 1, 0, 1, EW_Y, 1);
        doReset();
        runPhase(NS_G,     8, 0, 1, 0, 1, 0);
        runPhase(NS_Y,     3, 0, 1, 0, 1, 0);
        runPhase(AR_TO_EW, 1, 0, 1, 0, 1, 0);
        runPhase(EW_G,     3, 0, 1, 0, 1, 0);

        // Let the monitor drain, bounded to a few cycles.
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_intersection_scheduler.md
Name: traffic_intersection_scheduler

Overview:
- Sequences right-of-way at a two-road intersection: North-South (NS) and East-West (EW) roads plus one pedestrian crossing.
- Shares the crossing between the two vehicle approaches and pedestrians, using phase timers plus sensor demand (gap-out/max-out).
- Sits above the per-road light drivers; its light outputs feed the lamp logic directly.

Parameters:
- T_MIN_GREEN, 8: minimum green cycles per road.
- T_MAX_GREEN, 20: maximum green cycles while the opposing road has demand.
- T_YELLOW, 3: yellow cycles.
- T_ALL_RED, 1: all-red clearance cycles.
- T_WALK, 6: pedestrian walk cycles.
- CNT_W, 5: timer width; must hold T_MAX_GREEN-1.

Ports:
- clk  in  1  rising-edge clock.
- res  in  1  synchronous reset, active-high.
- en  in  1  1 = timer and state advance; 0 = freeze.
- car_ns  in  1  level: vehicle waiting or present on NS.
- car_ew  in  1  level: vehicle waiting or present on EW.
- ped_req  in  1  pedestrian button; sampled every cycle.
- ns_light  out  3  one-hot {R,Y,G}: 100 red, 010 yellow, 001 green.
- ew_light  out  3  same encoding as ns_light.
- walk  out  1  pedestrian walk lamp.
- ped_pending  out  1  latched pedestrian request not yet served.
- state  out  3  current state encoding, for debug.

Behaviour:
- States: NS_G, NS_Y, AR_TO_EW, EW_G, EW_Y, AR_TO_NS, WALK_TO_EW, WALK_TO_NS.
- Outputs are a combinational decode of the registered state.
  - NS_G: ns=001, ew=100.
  - NS_Y: ns=010, ew=100.
  - EW_G: ns=100, ew=001.
  - EW_Y: ns=100, ew=010.
  - AR_*: ns=100, ew=100.
  - WALK_*: ns=100, ew=100, walk=1.
  - walk=0 in every other state.
- Reset (res=1 at an edge, any state, any en): state=NS_G, timer=0, ped_pending=0. Outputs then read ns=001, ew=100, walk=0.
- Timer:
  - Increments on each en=1 cycle.
  - Clears to 0 on every state change.
  - Saturates at T_MAX_GREEN-1.
  - Holds when en=0.
- NS_G -> NS_Y when all of:
  - en=1,
  - demand = car_ew | ped_pending,
  - timer >= T_MIN_GREEN-1,
  - (car_ns==0 OR timer == T_MAX_GREEN-1).
- No demand: NS_G holds indefinitely, with the timer saturated.
- EW_G: symmetric to NS_G, with demand = car_ns | ped_pending; exits to EW_Y.
- NS_Y -> AR_TO_EW at timer == T_YELLOW-1. EW_Y -> AR_TO_NS likewise.
- AR_TO_EW exit at timer == T_ALL_RED-1: to WALK_TO_EW if ped_pending, else to EW_G. AR_TO_NS mirrors this.
- WALK_TO_EW -> EW_G at timer == T_WALK-1. WALK_TO_NS -> NS_G likewise.
- ped_pending:
  - Set by ped_req=1 in any cycle, regardless of en.
  - Cleared on the edge that enters a WALK_* state; ped_req in that same cycle is absorbed (clear wins).
  - ped_req during WALK_* is ignored.
- en=0: state and timer frozen; outputs hold; ped_pending still captures requests.
- Never both roads non-red. A yellow is always followed by at least T_ALL_RED all-red cycles.

Decomposition:
- Package traffic_pkg holds:
  - state encodings (3-bit localparams),
  - light constants LT_RED=3'b100, LT_YEL=3'b010, LT_GRN=3'b001.
- One sub-module, traffic_phase_timer:
  - inputs: clk, res, en, clr;
  - counter: CNT_W-bit, saturating;
  - outputs: count, plus compare helpers.
- FSM, request latch and output decode stay in the top module.

Test Plan:
Cycle n = n-th en=1 edge after res deasserts.
1. Reset, car_ew=1, car_ns=0, no ped -> NS_G cycles 0-7, NS_Y 8-10, AR_TO_EW 11, EW_G from 12 (ew_light=001).
2. car_ns=car_ew=1 constant -> NS_G 0-19, NS_Y 20-22, AR 23, EW_G 24-43, EW_Y 44-46, AR 47, NS_G at 48 (max-out both roads).
3. No cars, ped_req pulse at cycle 2 -> ped_pending=1 from 3; NS_Y 8-10; AR 11; WALK_TO_EW 12-17 (walk=1, both lights 100, ped_pending=0 from 12); EW_G from 18 and holds.
4. No demand for 100 cycles -> remains NS_G, walk=0, ns=001 throughout.
5. Scenario 1 with en=0 for 5 cycles during NS_Y -> yellow lasts 8 clocks, outputs frozen; a ped_req during the freeze sets ped_pending.
6. res=1 for one edge while in EW_Y -> next cycle state=NS_G, ns=001, ew=100, ped_pending=0, timer restarts at 0.
